fabric_vc_fifo: RTL and testbench

Multi-virtual-channel synchronous flit FIFO for the fabric port output path. It generalises the single-queue tail-lookahead FIFO to NUM_VC independent queues of arbitrary (non-power-of-2) depth, sharing one write port and one read port. It adds per-VC complete-packet tracking, an optional whole-packet read mode, and sticky overflow/underflow error flags. It sits between the NoC egress and the fabric-side packet reassembly / arbiter.

---
 rtl/fabric_fifo_pkg.sv | 23 ++
 rtl/fabric_vc_queue_ctrl.sv | 99 +++++++++
 rtl/fabric_vc_fifo.sv | 142 ++++++++++++++
 tb/tb_fabric_vc_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fabric_fifo_pkg.sv
// fabric_fifo_pkg
//   Shared helpers for the fabric egress path: flit field positions derived
//   from the flit width, and the VC index width derived from the VC count.
//   Flit layout, MSB first: valid, head, tail, payload.
package fabric_fifo_pkg;

    function automatic int flit_valid_bit(input int width);
        return width - 1;
    endfunction

    function automatic int flit_head_bit(input int width);
        return width - 2;
    endfunction

    function automatic int flit_tail_bit(input int width);
        return width - 3;
    endfunction

    function automatic int vc_idx_w(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

endpackage

// File: rtl/fabric_vc_queue_ctrl.sv
// fabric_vc_queue_ctrl
//   Bookkeeping for one virtual channel of fabric_vc_fifo: read/write
//   pointers, word count and complete-packet count. Produces the per-VC
//   flags and the accept strobes; storage lives in the parent.
// Ports
//   clk, preset_full (async, active-high), clear (sync)
//   wr_req_i / wr_tail_i : write addressed to this VC, tail bit of that flit
//   rd_req_i / rd_tail_i : read addressed to this VC, tail bit of head flit
//   wr_acc_o / rd_acc_o  : request accepted this cycle
//   wr_ptr_o / rd_ptr_o  : current slot pointers (0..DEPTH-1)
//   full_o, empty_o, almost_empty_o, read_ready_o : flags from registered state
module fabric_vc_queue_ctrl
    import fabric_fifo_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int PACKET_MODE = 0,
    parameter int PTR_W       = $clog2(DEPTH),
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             preset_full,
    input  logic             clear,
    input  logic             wr_req_i,
    input  logic             wr_tail_i,
    input  logic             rd_req_i,
    input  logic             rd_tail_i,
    output logic             wr_acc_o,
    output logic             rd_acc_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_empty_o,
    output logic             read_ready_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pkt_q, pkt_d;
    logic             pkt_inc, pkt_dec;

    assign full_o         = (cnt_q == CNT_W'(DEPTH));
    assign empty_o        = (cnt_q == '0);
    assign almost_empty_o = (cnt_q <= CNT_W'(1));
    assign read_ready_o   = (PACKET_MODE != 0) ? (pkt_q != '0) : ~empty_o;

    // Both sides judged on pre-cycle flags: a full VC still accepts a read,
    // an empty VC still accepts a write, and there is no bypass.
    assign wr_acc_o = wr_req_i & ~full_o;
    assign rd_acc_o = rd_req_i & read_ready_o;

    assign pkt_inc = wr_acc_o & wr_tail_i;
    assign pkt_dec = rd_acc_o & rd_tail_i;

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        pkt_d    = pkt_q;
        if (wr_acc_o)
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (rd_acc_o)
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({wr_acc_o, rd_acc_o})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        case ({pkt_inc, pkt_dec})
            2'b10:   pkt_d = pkt_q + 1'b1;
            2'b01:   pkt_d = pkt_q - 1'b1;
            default: pkt_d = pkt_q;
        endcase
    end

    always_ff @(posedge clk or posedge preset_full) begin
        if (preset_full) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            pkt_q    <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            pkt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            pkt_q    <= pkt_d;
        end
    end

endmodule

// File: rtl/fabric_vc_fifo.sv
// fabric_vc_fifo
//   Multi-VC synchronous flit FIFO for the fabric port output path. NUM_VC
//   independent queues of DEPTH entries share one write and one read port.
//   Optional whole-packet read mode, sticky overflow/underflow flags.
// Ports
//   clk, preset_full (async, active-high), clear (sync, same effect)
//   i_data_in, i_vc, i_write_en      : write port; i_full_out per-VC full
//   o_vc, o_read_en                  : read port
//   o_data_out, o_valid_out          : registered read data, 1-cycle latency
//   o_empty_out, o_almost_empty_out, o_next_is_tail, o_read_ready : per-VC
//   o_overflow, o_underflow          : sticky error flags
module fabric_vc_fifo
    import fabric_fifo_pkg::*;
#(
    parameter int WIDTH       = 36,
    parameter int DEPTH       = 8,
    parameter int NUM_VC      = 2,
    parameter int PACKET_MODE = 0,
    parameter int VC_W        = vc_idx_w(NUM_VC)
) (
    input  logic              clk,
    input  logic              preset_full,
    input  logic              clear,
    input  logic [WIDTH-1:0]  i_data_in,
    input  logic [VC_W-1:0]   i_vc,
    input  logic              i_write_en,
    output logic [NUM_VC-1:0] i_full_out,
    input  logic [VC_W-1:0]   o_vc,
    input  logic              o_read_en,
    output logic [WIDTH-1:0]  o_data_out,
    output logic              o_valid_out,
    output logic [NUM_VC-1:0] o_empty_out,
    output logic [NUM_VC-1:0] o_almost_empty_out,
    output logic [NUM_VC-1:0] o_next_is_tail,
    output logic [NUM_VC-1:0] o_read_ready,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int TAIL_BIT = flit_tail_bit(WIDTH);
    localparam int ENTRIES  = NUM_VC * DEPTH;
    localparam int ADDR_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int PTR_W    = $clog2(DEPTH);

    // Shared storage, VC v occupies entries v*DEPTH .. v*DEPTH+DEPTH-1.
    logic [WIDTH-1:0] mem [ENTRIES];

    logic [NUM_VC-1:0]             wr_req, rd_req, wr_acc, rd_acc, head_tail;
    logic [NUM_VC-1:0][PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [NUM_VC-1:0][ADDR_W-1:0] wr_addr_v, rd_addr_v;

    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              wr_any, rd_any;

    logic [WIDTH-1:0] data_q;
    logic             valid_q, ovf_q, udf_q;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        localparam int BASE = v * DEPTH;

        assign wr_req[v]    = i_write_en & (i_vc == VC_W'(v));
        assign rd_req[v]    = o_read_en & (o_vc == VC_W'(v));
        assign wr_addr_v[v] = ADDR_W'(BASE) + ADDR_W'(wr_ptr[v]);
        assign rd_addr_v[v] = ADDR_W'(BASE) + ADDR_W'(rd_ptr[v]);
        assign head_tail[v] = mem[rd_addr_v[v]][TAIL_BIT];
        // Memory is not reset, so the head flit is only meaningful when non-empty.
        assign o_next_is_tail[v] = ~o_empty_out[v] & head_tail[v];

        fabric_vc_queue_ctrl #(
            .DEPTH       (DEPTH),
            .PACKET_MODE (PACKET_MODE)
        ) u_ctrl (
            .clk            (clk),
            .preset_full    (preset_full),
            .clear          (clear),
            .wr_req_i       (wr_req[v]),
            .wr_tail_i      (i_data_in[TAIL_BIT]),
            .rd_req_i       (rd_req[v]),
            .rd_tail_i      (head_tail[v]),
            .wr_acc_o       (wr_acc[v]),
            .rd_acc_o       (rd_acc[v]),
            .wr_ptr_o       (wr_ptr[v]),
            .rd_ptr_o       (rd_ptr[v]),
            .full_o         (i_full_out[v]),
            .empty_o        (o_empty_out[v]),
            .almost_empty_o (o_almost_empty_out[v]),
            .read_ready_o   (o_read_ready[v])
        );
    end

    // At most one VC accepts per port, so an OR-style select is enough.
    always_comb begin
        wr_any  = 1'b0;
        rd_any  = 1'b0;
        wr_addr = '0;
        rd_addr = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_acc[v]) begin
                wr_any  = 1'b1;
                wr_addr = wr_addr_v[v];
            end
            if (rd_acc[v]) begin
                rd_any  = 1'b1;
                rd_addr = rd_addr_v[v];
            end
        end
    end

    // Accepted read and write never share a slot: equal pointers imply
    // empty (read rejected) or full (write rejected).
    always_ff @(posedge clk) begin
        if (wr_any && !clear)
            mem[wr_addr] <= i_data_in;
    end

    always_ff @(posedge clk or posedge preset_full) begin
        if (preset_full) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (clear) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            valid_q <= rd_any;
            if (rd_any)
                data_q <= mem[rd_addr];
            // A write to an out-of-range VC index is also a rejected write.
            ovf_q <= ovf_q | (i_write_en & ~wr_any);
            udf_q <= udf_q | (o_read_en & ~rd_any);
        end
    end

    assign o_data_out  = data_q;
    assign o_valid_out = valid_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = udf_q;

endmodule

// File: tb/tb_fabric_vc_fifo.sv
// tb_fabric_vc_fifo
//   Two instances (stream mode and packet mode) share one stimulus stream;
//   each is compared every cycle against a queue-based reference model.
module tb_fabric_vc_fifo;

    localparam int W  = 36;
    localparam int D  = 5;
    localparam int NV = 2;

    logic          clk = 1'b0;
    logic          preset_full, clear;
    logic [W-1:0]  i_data_in;
    logic          i_vc, o_vc, i_write_en, o_read_en;

    logic [NV-1:0] full_w [2], empty_w [2], aempty_w [2], ntail_w [2], rdy_w [2];
    logic [W-1:0]  data_w [2];
    logic          valid_w [2], ovf_w [2], udf_w [2];

    always #5 clk = ~clk;

    fabric_vc_fifo #(.WIDTH(W), .DEPTH(D), .NUM_VC(NV), .PACKET_MODE(0)) u_dut0 (
        .clk(clk), .preset_full(preset_full), .clear(clear),
        .i_data_in(i_data_in), .i_vc(i_vc), .i_write_en(i_write_en),
        .i_full_out(full_w[0]), .o_vc(o_vc), .o_read_en(o_read_en),
        .o_data_out(data_w[0]), .o_valid_out(valid_w[0]),
        .o_empty_out(empty_w[0]), .o_almost_empty_out(aempty_w[0]),
        .o_next_is_tail(ntail_w[0]), .o_read_ready(rdy_w[0]),
        .o_overflow(ovf_w[0]), .o_underflow(udf_w[0]));

    fabric_vc_fifo #(.WIDTH(W), .DEPTH(D), .NUM_VC(NV), .PACKET_MODE(1)) u_dut1 (
        .clk(clk), .preset_full(preset_full), .clear(clear),
        .i_data_in(i_data_in), .i_vc(i_vc), .i_write_en(i_write_en),
        .i_full_out(full_w[1]), .o_vc(o_vc), .o_read_en(o_read_en),
        .o_data_out(data_w[1]), .o_valid_out(valid_w[1]),
        .o_empty_out(empty_w[1]), .o_almost_empty_out(aempty_w[1]),
        .o_next_is_tail(ntail_w[1]), .o_read_ready(rdy_w[1]),
        .o_overflow(ovf_w[1]), .o_underflow(udf_w[1]));

    // Reference model: queue index = mode*2 + vc.
    logic [W-1:0] mq [4][$];
    logic [W-1:0] m_dat [2];
    logic         m_vld [2], m_ovf [2], m_udf [2];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int tails(input int qi);
        int n = 0;
        foreach (mq[qi][k]) if (mq[qi][k][W-3]) n++;
        return n;
    endfunction

    function automatic bit m_ready(input int m, input int v);
        return (m == 1) ? (tails(m*2+v) != 0) : (mq[m*2+v].size() != 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        for (int m = 0; m < 2; m++) begin
            m_dat[m] = '0; m_vld[m] = 1'b0; m_ovf[m] = 1'b0; m_udf[m] = 1'b0;
        end
    endtask

    task automatic check_all(input string ph);
        for (int m = 0; m < 2; m++) begin
            logic [NV-1:0] ef, ee, ea, et, er;
            for (int v = 0; v < NV; v++) begin
                int qi = m*2 + v;
                ef[v] = (mq[qi].size() == D);
                ee[v] = (mq[qi].size() == 0);
                ea[v] = (mq[qi].size() <= 1);
                et[v] = (mq[qi].size() != 0) && mq[qi][0][W-3];
                er[v] = m_ready(m, v);
            end
            chk($sformatf("%s m%0d full", ph, m),   64'(full_w[m]),   64'(ef));
            chk($sformatf("%s m%0d empty", ph, m),  64'(empty_w[m]),  64'(ee));
            chk($sformatf("%s m%0d aempty", ph, m), 64'(aempty_w[m]), 64'(ea));
            chk($sformatf("%s m%0d ntail", ph, m),  64'(ntail_w[m]),  64'(et));
            chk($sformatf("%s m%0d ready", ph, m),  64'(rdy_w[m]),    64'(er));
            chk($sformatf("%s m%0d valid", ph, m),  64'(valid_w[m]),  64'(m_vld[m]));
            chk($sformatf("%s m%0d data", ph, m),   64'(data_w[m]),   64'(m_dat[m]));
            chk($sformatf("%s m%0d ovf", ph, m),    64'(ovf_w[m]),    64'(m_ovf[m]));
            chk($sformatf("%s m%0d udf", ph, m),    64'(udf_w[m]),    64'(m_udf[m]));
        end
    endtask

    // One clock: drive at negedge, model the cycle, check #1 after posedge.
    task automatic step(input string ph, input bit we, input int wv, input logic [W-1:0] d,
                        input bit re, input int rv, input bit clr);
        i_write_en = we; i_vc = wv[0]; i_data_in = d;
        o_read_en = re; o_vc = rv[0]; clear = clr;
        if (clr) model_reset();
        else begin
            for (int m = 0; m < 2; m++) begin
                bit rdy = m_ready(m, rv);
                bit ful = (mq[m*2+wv].size() == D);
                if (re && rdy) begin
                    m_dat[m] = mq[m*2+rv].pop_front();
                    m_vld[m] = 1'b1;
                end else begin
                    m_vld[m] = 1'b0;
                    if (re) m_udf[m] = 1'b1;
                end
                if (we) begin
                    if (!ful) mq[m*2+wv].push_back(d);
                    else m_ovf[m] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1 check_all(ph);
        @(negedge clk);
        i_write_en = 1'b0; o_read_en = 1'b0; clear = 1'b0;
    endtask

    function automatic logic [W-1:0] flit(input bit h, input bit t);
        logic [32:0] p = 33'($urandom());
        return {1'b1, h, t, p};
    endfunction

    task automatic wr(input string ph, input int v, input logic [W-1:0] d);
        step(ph, 1'b1, v, d, 1'b0, 0, 1'b0);
    endtask

    task automatic rd(input string ph, input int v);
        step(ph, 1'b0, 0, '0, 1'b1, v, 1'b0);
    endtask

    task automatic clr_cycle(input string ph);
        step(ph, 1'b0, 0, '0, 1'b0, 0, 1'b1);
    endtask

    initial begin
        preset_full = 1'b1; clear = 1'b0; i_data_in = '0; i_vc = 1'b0; o_vc = 1'b0;
        i_write_en = 1'b0; o_read_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        preset_full = 1'b0;
        #1 check_all("reset");
        @(negedge clk);

        // Fill VC0 past capacity, then drain.
        for (int i = 0; i < 6; i++) wr("fill", 0, flit(i == 0, i == 4));
        for (int i = 0; i < 5; i++) rd("drain", 0);
        rd("drain_empty", 0);

        // Interleaved VCs crossing pointer wrap.
        clr_cycle("clr1");
        for (int i = 0; i < 12; i++)
            step("ilv", 1'b1, i % 2, flit(1'b0, i % 3 == 2), i >= 2, (i + 1) % 2, 1'b0);
        for (int i = 0; i < 6; i++) rd("ilv_rd", i % 2);

        // Head / body / tail on VC1.
        clr_cycle("clr2");
        wr("pkt", 1, flit(1'b1, 1'b0));
        wr("pkt", 1, flit(1'b0, 1'b0));
        wr("pkt", 1, flit(1'b0, 1'b1));
        for (int i = 0; i < 3; i++) rd("pkt_rd", 1);

        // Incomplete packet on VC0: packet-mode instance must refuse.
        clr_cycle("clr3");
        wr("pm", 0, flit(1'b1, 1'b0));
        wr("pm", 0, flit(1'b0, 1'b0));
        rd("pm_rej", 0);
        wr("pm", 0, flit(1'b0, 1'b1));
        wr("pm", 0, flit(1'b1, 1'b1));
        for (int i = 0; i < 4; i++) rd("pm_rd", 0);

        // Same-VC read+write on empty, full, and cnt=2.
        clr_cycle("clr4");
        step("rw_empty", 1'b1, 0, flit(1'b1, 1'b1), 1'b1, 0, 1'b0);
        for (int i = 0; i < 4; i++) wr("rw_fill", 0, flit(1'b0, 1'b1));
        step("rw_full", 1'b1, 0, flit(1'b0, 1'b1), 1'b1, 0, 1'b0);
        for (int i = 0; i < 2; i++) rd("rw_dn", 0);
        step("rw_two", 1'b1, 0, flit(1'b0, 1'b1), 1'b1, 0, 1'b0);
        rd("rw_dn", 0);
        step("rw_two", 1'b1, 0, flit(1'b0, 1'b0), 1'b1, 0, 1'b0);

        // Async reset mid-stream, between edges.
        for (int i = 0; i < 3; i++) wr("pre_rst", i % 2, flit(1'b0, 1'b1));
        rd("pre_rst", 0);
        #2 preset_full = 1'b1;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clk);
        preset_full = 1'b0;
        rd("post_rst", 0);
        rd("post_rst", 1);

        // Clear mid-stream, with a same-cycle write and read that must be ignored.
        clr_cycle("clr5");
        for (int i = 0; i < 3; i++) wr("pre_clr", 1, flit(1'b0, 1'b1));
        rd("pre_clr", 1);
        step("clr_mid", 1'b1, 1, flit(1'b0, 1'b1), 1'b1, 1, 1'b1);
        rd("post_clr", 1);

        // Randomized traffic.
        clr_cycle("clr6");
        for (int i = 0; i < 400; i++) begin
            bit we = ($urandom_range(0, 99) < 60);
            bit re = ($urandom_range(0, 99) < 50);
            bit cl = ($urandom_range(0, 99) == 0);
            step("rand", we, $urandom_range(0, 1), flit($urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0), re, $urandom_range(0, 1), cl);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
